// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_if
// Brief    : Instruction-memory handshake and datapath strobe bundle for the
//            multi-cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_control_if #(
  parameter int CNT_W = 16
);
  logic             imem_ready;
  logic [1:0]       opcode;
  logic             halt;
  logic             imem_req;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCSrc;
  logic             RegWrite;
  logic             ALU_Ctrl;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] retired;

  // The sequencer drives the strobes and consumes memory/IR/halt inputs.
  modport master (
    input  imem_ready, opcode, halt,
    output imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALU_Ctrl,
           illegal, halted, retired
  );

  modport slave (
    output imem_ready, opcode, halt,
    input  imem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALU_Ctrl,
           illegal, halted, retired
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Brief    : FETCH/DECODE/EXEC/WB sequencer for the 2-bit-opcode processor.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_cycle_control_if.master  bus
);

  localparam logic [1:0] c_op_mov  = 2'b00;
  localparam logic [1:0] c_op_addi = 2'b01;
  localparam logic [1:0] c_op_ill  = 2'b10;
  localparam logic [1:0] c_op_jump = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             halt_pend_q;

  logic             w_retire;
  logic             w_halt_now;

  // Jumps retire in EXEC; mov/addi retire in WB.
  assign w_retire   = (state_q == S_WB) ||
                      ((state_q == S_EXEC) && (bus.opcode == c_op_jump));
  assign w_halt_now = halt_pend_q | bus.halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      if (bus.halt && (state_q != S_HALT)) begin
        halt_pend_q <= 1'b1;
      end
      if (w_retire) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ready) begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (bus.opcode == c_op_ill) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.opcode == c_op_jump) begin
            state_q <= w_halt_now ? S_HALT : S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB:    state_q <= w_halt_now ? S_HALT : S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are a pure decode of state, except the FETCH write strobes which
  // must coincide with the memory data being valid.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALU_Ctrl = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.IRWrite  = bus.imem_ready;
        bus.PCWrite  = bus.imem_ready;
      end
      S_EXEC: begin
        bus.ALU_Ctrl = (bus.opcode == c_op_mov);
        if (bus.opcode == c_op_jump) begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = 1'b1;
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.ALU_Ctrl = (bus.opcode == c_op_mov);
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.retired = retired_q;

  // addi has no dedicated decode beyond defaulting ALU_Ctrl to add.
  logic w_unused_addi;
  assign w_unused_addi = (bus.opcode == c_op_addi);

endmodule
`default_nettype wire

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle sequencer for the 2-bit-opcode processor: mov (00), addi (01), jump (11). It replaces purely combinational decode with a FETCH/DECODE/EXEC/WB state machine. It handshakes with a variable-latency instruction memory, strobes IR/PC/register-file writes one per instruction, counts retired instructions, and stops on an illegal opcode or a halt request.

## Interface

Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous and active-low
- imem_ready  in  1  instruction memory data valid for the outstanding request
- opcode  in  2  IR[7:6], the IR output; meaningful from DECODE onward
- halt  in  1  stop request, honoured at the next retire boundary
- imem_req  out  1  instruction fetch request
- IRWrite  out  1  load the instruction register
- PCWrite  out  1  update the PC
- PCSrc  out  1  PC source: 0 = PC+1, 1 = jump target
- RegWrite  out  1  register file write enable
- ALU_Ctrl  out  1  ALU operation: 1 = pass (mov), 0 = add (addi)
- illegal  out  1  sticky; opcode 10 was decoded
- halted  out  1  FSM is in HALT
- retired  out  CNT_W  count of retired instructions

## Operation

- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. State is registered.
- Outputs are decoded from state. IRWrite and PCWrite in FETCH also depend on imem_ready.
- Any output not listed for a state is 0 in that state.
- IDLE (reset state): all strobes 0. Goes to FETCH unconditionally.
- FETCH: imem_req = 1.
  - While imem_ready = 0, stay in FETCH.
  - When imem_ready = 1: IRWrite = 1, PCWrite = 1, PCSrc = 0 in the same cycle, then go to DECODE.
- DECODE: all strobes 0.
  - opcode 00, 01 or 11 goes to EXEC.
  - opcode 10 sets illegal and goes to HALT. This is not a retire.
- EXEC:
  - mov: ALU_Ctrl = 1, go to WB.
  - addi: ALU_Ctrl = 0, go to WB.
  - jump: PCWrite = 1, PCSrc = 1, ALU_Ctrl = 0. This is the retire point.
- WB: RegWrite = 1, and ALU_Ctrl holds its EXEC value for the opcode. This is the retire point.
- Retire point behaviour:
  - retired increments by 1 and wraps modulo 2^CNT_W.
  - Next state is HALT if halt_pend = 1 or halt = 1 in this cycle; otherwise FETCH.
- halt_pend: internal flag.
  - Set when halt = 1 in any state except HALT.
  - Cleared on reset.
  - A halt arriving in FETCH does not abort the fetch; the current instruction completes.
- HALT: all strobes 0, halted = 1. Stays in HALT until rst_n = 0.
- imem_ready is ignored outside FETCH. opcode is ignored outside DECODE, EXEC and WB.
- opcode must stay stable from DECODE through WB. This holds because the IR is written only in FETCH.

## Timing

- Reset: a rising edge with rst_n = 0 in any state puts the FSM in IDLE, clears retired, illegal and halt_pend, and drives every output to 0. This includes reset mid-instruction, e.g. in EXEC or WB.
- Cycles per instruction with imem_ready already high on entry to FETCH:
  - mov/addi: 4 (FETCH, DECODE, EXEC, WB).
  - jump: 3 (FETCH, DECODE, EXEC).
  - Each cycle of imem_ready = 0 in FETCH adds 1.
- After rst_n is released, the first imem_req goes high 1 cycle later (the IDLE cycle).
- Per instruction, IRWrite, RegWrite and the jump PCWrite are each exactly one cycle wide.
- retired updates on the clock edge that ends the retire-point cycle.
- halted rises on the edge after the retire point or the illegal decode.
- halt = 1 in the same cycle as a retire halts immediately after that instruction, and the instruction is still counted.

## Test plan

- Reset, imem_ready tied 1, opcode 00 → states IDLE, FETCH, DECODE, EXEC, WB; RegWrite = 1 only in WB with ALU_Ctrl = 1; retired = 1 after WB; next state FETCH.
- opcode 01, imem_ready asserted 3 cycles after FETCH entry → imem_req high 4 cycles; IRWrite and PCWrite one pulse on the 4th with PCSrc = 0; ALU_Ctrl = 0 in EXEC and WB.
- Five back-to-back opcode 11 instructions → PCWrite with PCSrc = 1 once per EXEC; RegWrite never asserted; 15 cycles total; retired = 5.
- opcode 10 → illegal = 1 and halted = 1 one cycle after DECODE; retired unchanged; no RegWrite; imem_req stays 0 until reset.
- One-cycle halt pulse during DECODE of a mov → WB still completes; retired increments; FSM enters HALT; no further imem_req. A second test with halt = 1 exactly in the WB cycle must give the same result.
- CNT_W = 4, 17 mov instructions → retired = 1 (wrap). Then rst_n = 0 mid-EXEC → all outputs 0 and retired = 0 on the next cycle; sequence restarts at IDLE.
